fsm_detect_sched: RTL and testbench
===================================

# fsm_detect_sched

Scheduler that shares one two-in-a-row Moore pattern detector (`fsm_moore`-class datapath) among `N_REQ` streaming requesters. It round-robin-grants one requester per burst, clears the detector at burst start, and forwards beats with valid/ready. It counts detector matches for the burst and reports the count with the requester id. It sits between the requester stream ports and the single shared detector instance.

## Interface
- `N_REQ`, 4: number of requesters (2..8)
- `DW`, 2: beat width forwarded to the detector
- `CNT_W`, 8: match-counter width
- `IDW`, `$clog2(N_REQ)`: id width (localparam)

Ports:
- `clk` in 1: single clock, rising edge
- `rstn` in 1: asynchronous, active-low reset
- `i_req_valid` in `N_REQ`: per-requester beat valid
- `i_req_data` in `N_REQ*DW`: per-requester beat, requester k at `[k*DW +: DW]`
- `i_req_last` in `N_REQ`: beat is the last of the burst
- `o_req_ready` out `N_REQ`: one-hot ready to the granted requester only
- `o_det_clr` out 1: one-cycle clear to the detector, which returns it to init
- `o_det_valid` out 1: beat presented to the detector
- `o_det_data` out `DW`: beat data to the detector
- `i_det_match` in 1: detector Moore output; reflects the beat of the previous cycle
- `o_done` out 1: one-cycle burst-complete pulse
- `o_done_id` out `IDW`: requester whose burst completed; valid with `o_done`
- `o_done_cnt` out `CNT_W`: matches counted in that burst; valid with `o_done`

## Operation
- States:
  - IDLE: any `i_req_valid` set → latch the arbiter winner into `r_gnt`, go to CLR. No requester valid → stay.
  - CLR: `o_det_clr`=1, counter cleared. Go to STREAM unconditionally.
  - STREAM:
    - `o_req_ready[r_gnt]`=1; `o_det_valid`=`i_req_valid[r_gnt]`; `o_det_data`=granted slice.
    - A beat is accepted when valid&&ready.
    - An accepted beat with `i_req_last` → DRAIN.
  - DRAIN: one cycle to sample the match of the last beat → DONE.
  - DONE: `o_done`=1 with `o_done_id`/`o_done_cnt` → IDLE.
- Round-robin:
  - Priority starts at `r_ptr`; after a grant to k, `r_ptr`=(k+1) mod `N_REQ`.
  - Reset `r_ptr`=0, so requester 0 has highest priority.
- Match count:
  - `r_beat_d` registers "beat accepted" from the previous cycle.
  - Count increments when `r_beat_d`&&`i_det_match` in STREAM or DRAIN.
  - Saturates at 2^`CNT_W`−1 with no wrap.
- Grant is held for the whole burst. Valid gaps from the granted requester stall forwarding and add no counts.
- Other requesters' valids are ignored until IDLE. The arbiter re-evaluates only in IDLE.
- A single-beat burst (last on the first beat) is legal: the count is 0 or 1 per the detector.
- A requester dropping valid while in IDLE before grant is not an error. The grant is decided from that cycle's valids only.
- `rstn` low at any time forces IDLE immediately.

## Timing
- Reset values: `o_req_ready`=0, `o_det_clr`=0, `o_det_valid`=0, `o_det_data`=0, `o_done`=0, `o_done_id`=0, `o_done_cnt`=0, `r_ptr`=0, counter 0.
- Reset mid-burst aborts the burst with no `o_done`. The detector is cleared on the next grant's CLR.
- Request valid in IDLE at cycle t → CLR at t+1 → first ready at t+2.
- Last beat accepted at cycle t → DRAIN at t+1 → `o_done` at t+2 → IDLE at t+3. The earliest next CLR is t+4.
- `o_done_id`/`o_done_cnt` are registered and hold their values after `o_done` until the next DONE.
- `o_det_valid`/`o_det_data`/`o_req_ready` are combinational from state and `r_gnt`. No combinational path exists from `i_det_match` to any output.

## Structure
- Package `fsm_ctrl_pkg`: state encoding (IDLE, CLR, STREAM, DRAIN, DONE as a 3-bit localparam set) and default `N_REQ`/`DW`/`CNT_W`.
- Sub-module `rr_arbiter`: combinational rotating-priority pick from the `N_REQ` valids and `r_ptr`. Outputs a one-hot grant and an encoded id.
- Top holds the FSM, `r_gnt`, `r_ptr`, `r_beat_d`, the saturating counter and the done registers.

## Test plan
- Requester 0 only, burst 00,00,00,11(last), detector model attached → `o_det_clr` at t+1, ready at t+2, `o_done` with id 0 and cnt 2.
- Requesters 1 and 3 valid together after reset → grant 1, then 3. Next, all four valid → grant order 0,1,2,3 (rotation from `r_ptr`).
- Granted requester drops valid for 3 cycles mid-burst → `o_det_valid`=0 in the gap, no count change, grant held, other requesters' ready stays 0.
- Single-beat burst with last on the first beat → `o_done` exactly 2 cycles after acceptance, cnt 0.
- `CNT_W`=2 with a burst of 10 identical beats → `o_done_cnt`=3 (saturated).
- `rstn` pulsed low during STREAM → all outputs 0 that cycle, no `o_done`, next burst starts with CLR and grants requester 0 first.

Source files
------------

// File: rtl/fsm_ctrl_pkg.sv
// fsm_ctrl_pkg: state encoding and default parameters for the shared-detector scheduler
package fsm_ctrl_pkg;
    localparam int N_REQ_DEF = 4;
    localparam int DW_DEF    = 2;
    localparam int CNT_W_DEF = 8;
    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_CLR    = 3'd1,
        S_STREAM = 3'd2,
        S_DRAIN  = 3'd3,
        S_DONE   = 3'd4
    } state_t;
endpackage

// File: rtl/rr_arbiter.sv
// rr_arbiter: rotating-priority pick among N valids, searching upward from ptr
module rr_arbiter #(
    parameter int N = 4,
    localparam int IW = $clog2(N)
) (
    input  logic [N-1:0]  valid,
    input  logic [IW-1:0] ptr,
    output logic [N-1:0]  gnt,
    output logic [IW-1:0] gnt_id,
    output logic          any
);
    localparam logic [IW:0] NL = (IW+1)'(N);
    logic [2*N-1:0] dbl;
    logic [N-1:0]   rot;
    logic [IW:0]    sum;
    always_comb begin
        dbl = {valid, valid} >> ptr;
        rot = dbl[N-1:0];
        sum = '0;
        // descending scan so the lowest rotated position (closest to ptr) wins
        for (int i = N - 1; i >= 0; i--)
            sum = rot[i] ? ({1'b0, ptr} + (IW+1)'(i)) : sum;
        gnt_id = IW'(sum >= NL ? sum - NL : sum);
        any    = |valid;
        gnt    = any ? N'(1) << gnt_id : '0;
    end
endmodule

// File: rtl/fsm_detect_sched.sv
// fsm_detect_sched: round-robin burst scheduler sharing one two-in-a-row detector among N_REQ streams
module fsm_detect_sched
    import fsm_ctrl_pkg::*;
#(
    parameter int N_REQ = N_REQ_DEF,
    parameter int DW    = DW_DEF,
    parameter int CNT_W = CNT_W_DEF,
    localparam int IDW  = $clog2(N_REQ)
) (
    input  logic                clk,
    input  logic                rstn,
    input  logic [N_REQ-1:0]    i_req_valid,
    input  logic [N_REQ*DW-1:0] i_req_data,
    input  logic [N_REQ-1:0]    i_req_last,
    output logic [N_REQ-1:0]    o_req_ready,
    output logic                o_det_clr,
    output logic                o_det_valid,
    output logic [DW-1:0]       o_det_data,
    input  logic                i_det_match,
    output logic                o_done,
    output logic [IDW-1:0]      o_done_id,
    output logic [CNT_W-1:0]    o_done_cnt
);
    state_t           state, state_nx;
    logic [IDW-1:0]   r_gnt, r_ptr, arb_id, r_done_id;
    logic [N_REQ-1:0] r_gnt_oh, arb_gnt;
    logic             arb_any, r_beat_d, beat, last, cnt_inc;
    logic [CNT_W-1:0] r_cnt, cnt_nx, r_done_cnt;

    rr_arbiter #(.N(N_REQ)) u_arb (
        .valid  (i_req_valid),
        .ptr    (r_ptr),
        .gnt    (arb_gnt),
        .gnt_id (arb_id),
        .any    (arb_any)
    );

    always_comb begin
        beat     = state == S_STREAM && |(i_req_valid & r_gnt_oh);
        last     = |(i_req_last & r_gnt_oh);
        state_nx = state;
        unique case (state)
            S_IDLE:   state_nx = arb_any ? S_CLR : S_IDLE;
            S_CLR:    state_nx = S_STREAM;
            S_STREAM: state_nx = beat && last ? S_DRAIN : S_STREAM;
            S_DRAIN:  state_nx = S_DONE;
            S_DONE:   state_nx = S_IDLE;
            default:  state_nx = S_IDLE;
        endcase
        // the detector's Moore output lags its beat by one cycle, hence r_beat_d
        cnt_inc = r_beat_d && i_det_match && (state == S_STREAM || state == S_DRAIN);
        cnt_nx  = state == S_CLR ? '0 : (cnt_inc && r_cnt != '1) ? r_cnt + 1'b1 : r_cnt;
    end

    assign o_req_ready = state == S_STREAM ? r_gnt_oh : '0;
    assign o_det_valid = beat;
    assign o_det_data  = state == S_STREAM ? DW'(i_req_data >> (r_gnt * DW)) : '0;
    assign o_det_clr   = state == S_CLR;
    assign o_done      = state == S_DONE;
    assign o_done_id   = r_done_id;
    assign o_done_cnt  = r_done_cnt;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state      <= S_IDLE;
            r_gnt      <= '0;
            r_gnt_oh   <= '0;
            r_ptr      <= '0;
            r_beat_d   <= 1'b0;
            r_cnt      <= '0;
            r_done_id  <= '0;
            r_done_cnt <= '0;
        end else begin
            state    <= state_nx;
            r_beat_d <= beat;
            r_cnt    <= cnt_nx;
            if (state == S_IDLE && arb_any) begin
                r_gnt    <= arb_id;
                r_gnt_oh <= arb_gnt;
                r_ptr    <= arb_id == IDW'(N_REQ - 1) ? '0 : arb_id + 1'b1;
            end
            // cnt_nx already includes the last beat's match sampled in DRAIN
            if (state == S_DRAIN) begin
                r_done_id  <= r_gnt;
                r_done_cnt <= cnt_nx;
            end
        end
    end
endmodule

// File: tb/tb_fsm_detect_sched.sv
// tb_fsm_detect_sched: randomized scoreboard bench with a behavioural two-in-a-row detector
module tb_fsm_detect_sched;
    localparam int N   = 4;
    localparam int DW  = 2;
    localparam int CW  = 8;
    localparam int IDW = 2;
    localparam int SAT = (1 << CW) - 1;

    logic            clk = 1'b0, rstn = 1'b0;
    logic [N-1:0]    req_valid = '0, req_last = '0, req_ready;
    logic [N*DW-1:0] req_data = '0;
    logic            det_clr, det_valid, done;
    logic            det_match = 1'b0;
    logic [DW-1:0]   det_data;
    logic [IDW-1:0]  done_id;
    logic [CW-1:0]   done_cnt;

    fsm_detect_sched #(.N_REQ(N), .DW(DW), .CNT_W(CW)) dut (
        .clk         (clk),
        .rstn        (rstn),
        .i_req_valid (req_valid),
        .i_req_data  (req_data),
        .i_req_last  (req_last),
        .o_req_ready (req_ready),
        .o_det_clr   (det_clr),
        .o_det_valid (det_valid),
        .o_det_data  (det_data),
        .i_det_match (det_match),
        .o_done      (done),
        .o_done_id   (done_id),
        .o_done_cnt  (done_cnt)
    );

    always #5 clk = ~clk;

    typedef struct { int id; int cnt; int cyc; } exp_t;
    typedef struct { logic [DW-1:0] d; bit last; } beat_t;

    beat_t bq[N][$];
    int    ecnt[N][$];
    exp_t  sb[$];
    int    n_vec = 0, n_bad = 0, cyc = 0;
    int    m_ptr = 0, m_gnt = 0, m_clr = 0, m_free = 0;
    bit    m_busy = 0, m_last = 0, chaos = 0;
    bit    started[N];
    int    gap[N];

    always @(posedge clk) cyc <= cyc + 1;

    // detector: match when the current beat equals the previous beat since the last clear
    logic [DW-1:0] dprev = '0;
    bit dhave = 0;
    always @(posedge clk) begin
        if (det_clr) begin
            dhave     <= 0;
            det_match <= 1'b0;
        end else if (det_valid) begin
            det_match <= dhave && det_data == dprev;
            dprev     <= det_data;
            dhave     <= 1;
        end else det_match <= 1'b0;
    end

    task automatic chk(string name, int act, int exp);
        n_vec++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic push_burst(int k, logic [DW-1:0] d[$]);
        int m = 0;
        beat_t b;
        for (int i = 0; i < d.size(); i++) begin
            if (i > 0 && d[i] == d[i-1]) m++;
            b.d = d[i];
            b.last = i == d.size() - 1;
            bq[k].push_back(b);
        end
        ecnt[k].push_back(m > SAT ? SAT : m);
    endtask

    task automatic drive_cycle();
        logic [N-1:0] exp_rdy;
        bit strm;
        if (!rstn) begin
            req_valid = '0;
            req_last = '0;
            m_busy = 0;
            m_last = 0;
            m_ptr = 0;
            for (int k = 0; k < N; k++) begin
                started[k] = 0;
                gap[k] = 0;
            end
            return;
        end
        for (int k = 0; k < N; k++) begin
            logic [DW-1:0] d;
            bit v, l;
            d = DW'($urandom);
            l = 1'($urandom);
            v = 0;
            if (bq[k].size() > 0) begin
                if (chaos && started[k] && gap[k] == 0 && $urandom_range(0, 5) == 0)
                    gap[k] = $urandom_range(1, 3);
                v = started[k] ? gap[k] == 0 : (!chaos || $urandom_range(0, 7) != 0);
                if (gap[k] > 0) gap[k]--;
                if (v) begin
                    d = bq[k][0].d;
                    l = bq[k][0].last;
                end
            end
            req_valid[k] = v;
            req_last[k] = l;
            req_data[k*DW +: DW] = d;
        end
        #1;
        if (!m_busy && req_valid != '0) begin
            for (int i = 0; i < N; i++)
                if (req_valid[(m_ptr + i) % N]) begin
                    m_gnt = (m_ptr + i) % N;
                    break;
                end
            m_ptr = (m_gnt + 1) % N;
            m_busy = 1;
            m_last = 0;
            m_clr = cyc + 1;
        end
        strm = m_busy && !m_last && cyc > m_clr;
        exp_rdy = strm ? N'(1) << m_gnt : '0;
        chk("det_clr", det_clr, m_busy && cyc == m_clr);
        chk("req_ready", req_ready, exp_rdy);
        chk("det_valid", det_valid, strm && req_valid[m_gnt]);
        if (strm) chk("det_data", det_data, req_data[m_gnt*DW +: DW]);
        if (strm && req_valid[m_gnt]) begin
            started[m_gnt] = !req_last[m_gnt];
            void'(bq[m_gnt].pop_front());
            if (req_last[m_gnt]) begin
                exp_t e;
                e.id = m_gnt;
                e.cnt = ecnt[m_gnt].pop_front();
                e.cyc = cyc + 2;
                sb.push_back(e);
                m_last = 1;
                m_free = cyc + 3;
            end
        end
        if (m_last && cyc + 1 == m_free) m_busy = 0;
    endtask

    initial begin : driver
        forever begin
            @(negedge clk);
            drive_cycle();
        end
    end

    initial begin : monitor
        int last_id, last_cnt;
        exp_t e;
        last_id = 0;
        last_cnt = 0;
        forever begin
            @(negedge clk);
            #2;
            if (!rstn) begin
                last_id = 0;
                last_cnt = 0;
            end else if (done) begin
                if (sb.size() == 0) begin
                    n_vec++;
                    n_bad++;
                    $display("FAIL done_unexpected: o_done with id %0d cnt %0d, none expected (cycle %0d)", done_id, done_cnt, cyc);
                end else begin
                    e = sb.pop_front();
                    chk("done_id", done_id, e.id);
                    chk("done_cnt", done_cnt, e.cnt);
                    chk("done_cycle", cyc, e.cyc);
                    last_id = e.id;
                    last_cnt = e.cnt;
                end
            end else begin
                chk("done_id_hold", done_id, last_id);
                chk("done_cnt_hold", done_cnt, last_cnt);
                if (sb.size() > 0 && sb[0].cyc < cyc) begin
                    e = sb.pop_front();
                    chk("done_missing", 0, 1);
                end
            end
        end
    end

    task automatic wait_idle(int budget);
        int n = 0;
        while ((bq[0].size() + bq[1].size() + bq[2].size() + bq[3].size() + sb.size()) != 0 || m_busy) begin
            @(posedge clk);
            n++;
            if (n > budget) begin
                chk("idle_timeout", n, budget);
                return;
            end
        end
        repeat (2) @(posedge clk);
        #2;
    endtask

    task automatic check_quiet(string tag);
        chk({tag, "_ready"}, req_ready, 0);
        chk({tag, "_clr"}, det_clr, 0);
        chk({tag, "_dvalid"}, det_valid, 0);
        chk({tag, "_ddata"}, det_data, 0);
        chk({tag, "_done"}, done, 0);
        chk({tag, "_done_id"}, done_id, 0);
        chk({tag, "_done_cnt"}, done_cnt, 0);
    endtask

    initial begin : watchdog
        #500000;
        $display("FAIL watchdog: simulation did not finish, %0d vectors, %0d miscompares", n_vec, n_bad);
        $fatal(1);
    end

    initial begin : main
        logic [DW-1:0] d[$];
        int k, len, w;
        #1;
        check_quiet("reset");
        repeat (3) @(posedge clk);
        #2 rstn = 1'b1;
        d = {2'd0, 2'd0, 2'd0, 2'd3};
        push_burst(0, d);
        wait_idle(100);
        d = {2'd1, 2'd1, 2'd2};
        push_burst(1, d);
        d = {2'd3, 2'd3};
        push_burst(3, d);
        wait_idle(100);
        for (int r = 0; r < N; r++) begin
            d = {2'(r), 2'(r), 2'(r)};
            push_burst(r, d);
        end
        wait_idle(200);
        chaos = 1;
        d = {2'd1};
        push_burst(2, d);
        wait_idle(100);
        d = {};
        for (int i = 0; i < 300; i++) d.push_back(2'd2);
        push_burst(1, d);
        wait_idle(3000);
        for (int b = 0; b < 40; b++) begin
            k = $urandom_range(0, N - 1);
            len = $urandom_range(1, 8);
            d = {};
            for (int i = 0; i < len; i++)
                d.push_back((i > 0 && $urandom_range(0, 1) == 1) ? d[i-1] : 2'($urandom));
            push_burst(k, d);
            w = $urandom_range(0, 15);
            repeat (w) @(posedge clk);
            #2;
        end
        wait_idle(5000);
        d = {};
        for (int i = 0; i < 20; i++) d.push_back(2'($urandom));
        push_burst(0, d);
        w = 0;
        while (!(started[0] && bq[0].size() < 15) && w < 200) begin
            @(posedge clk);
            w++;
        end
        chk("reach_stream", w < 200, 1);
        @(posedge clk);
        #3 rstn = 1'b0;
        for (int r = 0; r < N; r++) begin
            bq[r] = {};
            ecnt[r] = {};
        end
        sb = {};
        #1;
        check_quiet("midrst");
        @(posedge clk);
        #2 rstn = 1'b1;
        d = {2'd2, 2'd2};
        push_burst(2, d);
        d = {2'd0, 2'd1, 2'd1};
        push_burst(0, d);
        wait_idle(200);
        chk("sb_drained", sb.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end
endmodule
